cacheline_adaptor: RTL and testbench

- Responder on the cache's physical-memory port: accepts one full-line pmem_read/pmem_write from the cache controller and completes it with a single-cycle pmem_resp.
- Translates each line transaction into a fixed-length burst of BEATS narrow transfers on the burst-memory interface.
- Sits between the cache and main memory or the arbiter.

---
 rtl/cache_types_pkg.sv | 25 ++
 rtl/cacheline_adaptor.sv | 137 +++++++++++++
 tb/tb_cacheline_adaptor.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_types_pkg
//  Description : Shared line/beat geometry, types and the adaptor state
//                encoding for the cache-to-burst-memory adaptor.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_types_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;

    typedef logic [LINE_WIDTH-1:0]  line_t;
    typedef logic [BURST_WIDTH-1:0] beat_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_READ_BURST  = 2'd1,
        ST_WRITE_BURST = 2'd2,
        ST_DONE        = 2'd3
    } adaptor_state_t;

endpackage : cache_types_pkg
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor
//  Description : Accepts one full cache-line read or write and carries it out
//                as a fixed-length burst of narrow beats on the memory side,
//                answering the cache with a single-cycle pmem_resp.
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = cache_types_pkg::LINE_WIDTH,
    parameter int BURST_WIDTH = cache_types_pkg::BURST_WIDTH,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [ADDR_WIDTH-1:0]  pmem_address,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,

    output logic [ADDR_WIDTH-1:0]  bmem_address,
    output logic                   bmem_read,
    output logic                   bmem_write,
    output logic [BURST_WIDTH-1:0] bmem_wdata,
    input  logic [BURST_WIDTH-1:0] bmem_rdata,
    input  logic                   bmem_resp
);

    import cache_types_pkg::*;

    localparam int c_beats    = LINE_WIDTH / BURST_WIDTH;
    localparam int c_cnt_w    = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_off_bits = $clog2(LINE_WIDTH / 8);

    // Clears the byte-within-line offset so every burst starts on a line boundary.
    localparam logic [ADDR_WIDTH-1:0] c_align_mask =
        ~ADDR_WIDTH'((64'd1 << c_off_bits) - 64'd1);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

    // Line buffer viewed as an array of beats, slot i = line bits [i*BURST_WIDTH +: BURST_WIDTH].
    typedef logic [c_beats-1:0][BURST_WIDTH-1:0] beats_t;

    adaptor_state_t          state_q, state_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    beats_t                  buf_q, buf_d;
    logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    // State register, beat counter, line buffer, latched address and read-line holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic: request acceptance, beat sequencing and completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;

        case (state_q)
            ST_IDLE: begin
                // Write wins when both requests are raised together.
                if (pmem_write) begin
                    buf_d   = pmem_wdata;
                    addr_d  = pmem_address & c_align_mask;
                    cnt_d   = '0;
                    state_d = ST_WRITE_BURST;
                end else if (pmem_read) begin
                    addr_d  = pmem_address & c_align_mask;
                    cnt_d   = '0;
                    state_d = ST_READ_BURST;
                end
            end

            ST_READ_BURST: begin
                if (bmem_resp) begin
                    buf_d[cnt_q] = bmem_rdata;
                    if (cnt_q == c_last_beat) begin
                        // The completed line is published here so it is visible
                        // during the DONE cycle and survives later write bursts.
                        rdata_d = buf_d;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_WRITE_BURST: begin
                if (bmem_resp) begin
                    if (cnt_q == c_last_beat) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All outputs are decoded from registers, so none depend combinationally on inputs.
    assign pmem_resp    = (state_q == ST_DONE);
    assign pmem_rdata   = rdata_q;
    assign bmem_read    = (state_q == ST_READ_BURST);
    assign bmem_write   = (state_q == ST_WRITE_BURST);
    assign bmem_address = addr_q;
    assign bmem_wdata   = buf_q[cnt_q];

endmodule : cacheline_adaptor
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adaptor
//  Description : Scoreboard bench for cacheline_adaptor with a behavioural
//                burst-memory responder and a line-level reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int NB = LW / BW;
    localparam int AW = 32;

    typedef logic [LW-1:0] line_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [AW-1:0] bmem_address;
    logic          bmem_read;
    logic          bmem_write;
    logic [BW-1:0] bmem_wdata;
    logic [BW-1:0] bmem_rdata;
    logic          bmem_resp;

    cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .bmem_address (bmem_address),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    // Memory as seen by the bus (filled by captured write beats) and the
    // reference memory (updated with whole lines when a write is issued).
    line_t bus_mem [logic [AW-1:0]];
    line_t ref_mem [logic [AW-1:0]];
    line_t exp_q[$];
    bit    pat_q[$];

    int            mode = 0;           // 0: back-to-back beats, 1: random gaps, 2: pattern
    bit            stray_en = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    bit            exp_rd = 1'b0;
    bit            exp_wr = 1'b0;
    int            beats = 0;
    int            last_beat_cyc = -10;
    line_t         last_read = '0;
    bit            prev_resp = 1'b0;

    function automatic line_t init_line(input logic [AW-1:0] a);
        line_t l;
        for (int b = 0; b < NB; b++) l[b*BW +: BW] = {a, 8'(b), 24'hA5C35A};
        return l;
    endfunction

    function automatic line_t bus_get(input logic [AW-1:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_line(a);
    endfunction

    function automatic line_t ref_get(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Issue one line request, wait for its completion, then drop the request.
    task automatic do_req(input bit rd, input bit wr, input logic [AW-1:0] a, input line_t wd);
        logic [AW-1:0] al;
        line_t         e;
        bit            done;
        al = a & 32'hFFFF_FFE0;
        @(negedge clk);
        pmem_address = a;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_wdata   = wd;
        exp_addr     = al;
        exp_rd       = rd && !wr;
        exp_wr       = wr;
        if (wr) begin
            ref_mem[al] = wd;
            e = last_read;
        end else begin
            e = ref_get(al);
            last_read = e;
        end
        exp_q.push_back(e);
        @(negedge clk);
        check("accept_read",  LW'(bmem_read),    LW'(exp_rd));
        check("accept_write", LW'(bmem_write),   LW'(exp_wr));
        check("accept_addr",  LW'(bmem_address), LW'(al));
        // Post-acceptance request changes must not matter.
        pmem_address = $urandom;
        pmem_wdata   = {8{$urandom}};
        if ($urandom_range(0, 3) == 0) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (pmem_resp) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=no_resp required=resp addr=%0h", al);
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    // Burst-memory responder: serves read beats from bus_mem, captures write beats.
    initial begin
        line_t bl;
        line_t rl;
        bit    give;
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bmem_resp = 1'b0;
            if (rst || !(bmem_read || bmem_write)) beats = 0;
            if ((bmem_read || bmem_write) && !rst && beats < NB) begin
                check("rw_kind", LW'({bmem_read, bmem_write}), LW'({exp_rd, exp_wr}));
                check("addr_hold", LW'(bmem_address), LW'(exp_addr));
                if (mode == 0)      give = 1'b1;
                else if (mode == 1) give = ($urandom_range(0, 2) != 0);
                else                give = (pat_q.size() != 0) ? pat_q.pop_front() : 1'b1;
                if (give) begin
                    bmem_resp = 1'b1;
                    bl = bus_get(bmem_address);
                    if (bmem_read) begin
                        bmem_rdata = bl[beats*BW +: BW];
                    end else begin
                        rl = ref_get(exp_addr);
                        check("wdata_beat", LW'(bmem_wdata), LW'(rl[beats*BW +: BW]));
                        bl[beats*BW +: BW] = bmem_wdata;
                        bus_mem[bmem_address] = bl;
                        bmem_rdata = {2{$urandom}};
                    end
                    beats++;
                    if (beats == NB) last_beat_cyc = cyc;
                end
            end else if (stray_en) begin
                bmem_resp  = 1'b1;
                bmem_rdata = {2{$urandom}};
            end
        end
    end

    // Monitor: every completion pulse is matched against the scoreboard.
    initial begin
        line_t e;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                if (prev_resp) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_width actual=2+cycles required=1cycle");
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_resp actual=resp required=no_resp cyc=%0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pmem_rdata", pmem_rdata, e);
                    check("resp_latency", LW'(cyc), LW'(last_beat_cyc + 1));
                end
            end
            prev_resp = pmem_resp;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t         l;
        line_t         wd;
        logic [AW-1:0] a;
        int            kind;
        bit            done;

        rst = 1'b1;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        repeat (2) @(negedge clk);
        check("rst_pmem_resp",  LW'(pmem_resp),    '0);
        check("rst_bmem_read",  LW'(bmem_read),    '0);
        check("rst_bmem_write", LW'(bmem_write),   '0);
        check("rst_pmem_rdata", pmem_rdata,        '0);
        check("rst_bmem_addr",  LW'(bmem_address), '0);
        check("rst_bmem_wdata", LW'(bmem_wdata),   '0);
        rst = 1'b0;

        // Read with back-to-back beats from a preloaded line.
        l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        bus_mem[32'h0000_1220] = l;
        ref_mem[32'h0000_1220] = l;
        mode = 0;
        do_req(1'b1, 1'b0, 32'h0000_1234, '0);

        // Write with a gapped response pattern.
        mode = 2;
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        wd = {{2{$urandom}}, {2{$urandom}}, {2{$urandom}}, {2{$urandom}}};
        do_req(1'b0, 1'b1, 32'h0000_4010, wd);

        // Both requests high: write wins, read line is untouched.
        mode = 1;
        wd = {8{$urandom}};
        do_req(1'b1, 1'b1, 32'h0000_5000, wd);

        // Reset after two read beats.
        mode = 0;
        @(negedge clk);
        pmem_address = 32'h0000_4008;
        pmem_read    = 1'b1;
        exp_addr     = 32'h0000_4000;
        exp_rd       = 1'b1;
        exp_wr       = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (beats >= 2) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rst_setup actual=no_beats required=2beats");
        end
        rst       = 1'b1;
        pmem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_bmem_read",  LW'(bmem_read),  '0);
        check("midrst_bmem_write", LW'(bmem_write), '0);
        check("midrst_pmem_resp",  LW'(pmem_resp),  '0);
        check("midrst_pmem_rdata", pmem_rdata,      '0);
        last_read = '0;
        do_req(1'b1, 1'b0, 32'h0000_4008, '0);

        // Stray beat strobes while idle.
        @(negedge clk);
        stray_en = 1'b1;
        repeat (3) @(negedge clk);
        stray_en = 1'b0;
        do_req(1'b1, 1'b0, 32'h0000_5004, '0);

        // Back-to-back requests with a new address right after completion.
        do_req(1'b1, 1'b0, 32'h0000_6000, '0);
        do_req(1'b1, 1'b0, 32'h0000_7fff, '0);

        // Randomised mix over a small set of lines so reads revisit writes.
        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 1);
            kind = $urandom_range(0, 2);
            a = 32'h0000_8000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
            wd = {8{$urandom}};
            do_req(kind != 1, kind != 0, a, wd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", LW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cacheline_adaptor
`default_nettype wire
